// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: FSM state encodings and small helpers shared by the
// program loader and its address/remaining counter.
package prog_loader_pkg;

    localparam int LDR_ST_W = 3;

    typedef enum logic [LDR_ST_W-1:0] {
        LDR_ST_IDLE  = 3'd0,
        LDR_ST_HDR   = 3'd1,
        LDR_ST_DATA  = 3'd2,
        LDR_ST_CKSUM = 3'd3,
        LDR_ST_DONE  = 3'd4
    } ldr_state_e;

    // The stream is accepted in every state that consumes a byte.
    function automatic logic ldr_accepts(input ldr_state_e st);
        return (st == LDR_ST_HDR) ||
               (st == LDR_ST_DATA) ||
               (st == LDR_ST_CKSUM);
    endfunction

endpackage

// File: rtl/ldr_addr_ctr.sv
// ldr_addr_ctr: wrapping RAM address counter plus down-counting
// remaining-byte counter for the program loader.
module ldr_addr_ctr
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              len_we_i,
    input  logic [CNT_W-1:0]  len_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;

    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        if (load_i) begin
            addr_d = BASE_ADDR;
            rem_d  = '0;
        end else begin
            if (len_we_i) begin
                rem_d = len_i;
            end
            if (step_i) begin
                // Address wraps naturally at 2^ADDR_W.
                addr_d = addr_q + ADDR_W'(1);
                if (rem_q != '0) begin
                    rem_d = rem_q - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= BASE_ADDR;
            rem_q  <= '0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (rem_q == '0);

endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams a LEN-prefixed image into CPU RAM while holding the CPU
// in reset. Define LOADER_CHECKSUM_EN to require a trailing checksum byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_start,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_write_en,
    output logic              cpu_hold,
    output logic              ld_done,
    output logic              ld_error
);

    ldr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              we_q;
    logic              hold_q, hold_d;

    logic              xfer;
    logic              start_load;
    logic              len_we;
    logic              step;
    logic              last;
    logic [ADDR_W-1:0] ctr_addr;

    assign ld_ready = ldr_accepts(state_q);
    assign xfer     = ld_valid & ld_ready;

    ldr_addr_ctr #(
        .ADDR_W    (ADDR_W),
        .CNT_W     (DATA_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .load_i   (start_load),
        .len_we_i (len_we),
        .len_i    (ld_data),
        .step_i   (step),
        .addr_o   (ctr_addr),
        .last_o   (last)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              err_q, err_d;
    logic              ck_bad;

    assign ck_bad = (ld_data != sum_q);
`endif

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        start_load = 1'b0;
        len_we     = 1'b0;
        step       = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        err_d      = err_q;
`endif
        unique case (state_q)
            LDR_ST_IDLE: begin
                if (ld_start) begin
                    state_d    = LDR_ST_HDR;
                    hold_d     = 1'b1;
                    start_load = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d      = '0;
                    err_d      = 1'b0;
`endif
                end
            end
            LDR_ST_HDR: begin
                if (xfer) begin
                    len_we  = 1'b1;
                    state_d = LDR_ST_DATA;
                end
            end
            LDR_ST_DATA: begin
                if (xfer) begin
                    step = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d = sum_q + ld_data;
                    if (last) begin
                        state_d = LDR_ST_CKSUM;
                    end
`else
                    // Without a checksum the image is trusted once written.
                    if (last) begin
                        state_d = LDR_ST_DONE;
                        hold_d  = 1'b0;
                    end
`endif
                end
            end
            LDR_ST_CKSUM: begin
`ifdef LOADER_CHECKSUM_EN
                if (xfer) begin
                    err_d   = ck_bad;
                    hold_d  = ck_bad;
                    state_d = LDR_ST_DONE;
                end
`else
                state_d = LDR_ST_IDLE;
`endif
            end
            LDR_ST_DONE: begin
                state_d = LDR_ST_IDLE;
            end
            default: begin
                state_d = LDR_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LDR_ST_IDLE;
            addr_q  <= BASE_ADDR;
            data_q  <= '0;
            we_q    <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            we_q    <= step;
            if (step) begin
                addr_q <= ctr_addr;
                data_q <= ld_data;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end

    assign ld_error = err_q;
`else
    assign ld_error = 1'b0;
`endif

    assign ram_addr     = addr_q;
    assign ram_data     = data_q;
    assign ram_write_en = we_q;
    assign cpu_hold     = hold_q;
    assign ld_done      = (state_q == LDR_ST_DONE);

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized stream loads checked every cycle against a
// transaction-level model, for BASE_ADDR=0 and a wrapping BASE_ADDR=0xFE.
module tb_prog_loader;

`ifdef LOADER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam logic [7:0] WBASE = 8'hFE;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ld_start = 1'b0;
    logic [7:0] ld_data = '0;
    logic       ld_valid = 1'b0;

    logic       ld_ready, ram_write_en, cpu_hold, ld_done, ld_error;
    logic [7:0] ram_addr, ram_data;
    logic       w_ready, w_we, w_hold, w_done, w_error;
    logic [7:0] w_addr, w_data;

    prog_loader u_dut (
        .clk(clk), .rst(rst), .ld_start(ld_start), .ld_data(ld_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ram_addr(ram_addr),
        .ram_data(ram_data), .ram_write_en(ram_write_en),
        .cpu_hold(cpu_hold), .ld_done(ld_done), .ld_error(ld_error)
    );

    prog_loader #(.BASE_ADDR(WBASE)) u_wrap (
        .clk(clk), .rst(rst), .ld_start(ld_start), .ld_data(ld_data),
        .ld_valid(ld_valid), .ld_ready(w_ready), .ram_addr(w_addr),
        .ram_data(w_data), .ram_write_en(w_we),
        .cpu_hold(w_hold), .ld_done(w_done), .ld_error(w_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model: counts accepted bytes of the current load
    bit         m_load, m_done;
    int         m_k, m_n, m_len;
    logic [7:0] m_sum;
    logic       e_ready, e_we, e_hold, e_done, e_err;
    logic [7:0] e_off, e_data;

    // log of writes seen on the DUT outputs, for literal checks
    logic [7:0] wa [0:1023];
    logic [7:0] wd [0:1023];
    logic [7:0] ww [0:1023];
    int         wcnt = 0;
    int         dcnt = 0;

    logic [7:0] stream [$];

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_load  = 0;
        m_done  = 0;
        m_k     = 0;
        m_n     = 0;
        m_len   = 0;
        m_sum   = '0;
        e_ready = 0;
        e_we    = 0;
        e_hold  = 1;
        e_done  = 0;
        e_err   = 0;
        e_off   = '0;
        e_data  = '0;
    endtask

    // Advance the model across the coming rising edge.
    task automatic m_step();
        bit fire;
        logic [7:0] b;
        fire = m_load && ld_valid;
        b    = ld_data;
        e_we = 0;
        if (m_done) begin
            m_done = 0;
        end else if (!m_load && ld_start) begin
            m_load = 1;
            m_k    = 0;
            m_sum  = '0;
            e_hold = 1;
            e_err  = 0;
        end
        if (fire) begin
            if (m_k == 0) begin
                m_len = int'(b);
                m_n   = m_len + 2 + CK;
            end else if (m_k <= m_len + 1) begin
                e_we   = 1;
                e_off  = 8'(m_k - 1);
                e_data = b;
                m_sum  = m_sum + b;
            end else begin
                e_err = (b != m_sum);
            end
            m_k++;
            if (m_k == m_n) begin
                m_load = 0;
                m_done = 1;
                e_hold = e_err;
            end
        end
        e_ready = m_load;
        e_done  = m_done;
    endtask

    initial m_reset();

    always @(negedge clk) begin
        if (rst) m_reset();
        chk("ready", ld_ready, e_ready);
        chk("we", ram_write_en, e_we);
        chk("addr", ram_addr, e_off);
        chk("data", ram_data, e_data);
        chk("hold", cpu_hold, e_hold);
        chk("done", ld_done, e_done);
        chk("error", ld_error, e_err);
        chk("w_ready", w_ready, e_ready);
        chk("w_we", w_we, e_we);
        chk("w_addr", w_addr, 8'(e_off + WBASE));
        chk("w_data", w_data, e_data);
        chk("w_hold", w_hold, e_hold);
        chk("w_done", w_done, e_done);
        chk("w_error", w_error, e_err);
        if (ram_write_en && wcnt < 1024) begin
            wa[wcnt] = ram_addr;
            wd[wcnt] = ram_data;
            ww[wcnt] = w_addr;
            wcnt++;
        end
        if (ld_done) dcnt++;
        if (!rst) m_step();
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] img_sum();
        logic [7:0] s = '0;
        for (int i = 1; i < stream.size(); i++) s = s + stream[i];
        return s;
    endfunction

    // Start a load and push the whole stream; alt toggles valid 1/0.
    task automatic send(input int pct, input bit alt, input bit poke);
        int  idx = 0;
        int  budget = 0;
        bit  fire;
        ld_start = 1;
        cyc();
        ld_start = 0;
        while (idx < stream.size() && budget < 3000) begin
            if (alt) ld_valid = (budget % 2 == 0);
            else     ld_valid = ($urandom_range(99) < pct);
            ld_data  = ld_valid ? stream[idx] : 8'($urandom);
            ld_start = poke && ($urandom_range(7) == 0);
            @(negedge clk);
            fire = ld_valid && ld_ready;
            @(posedge clk);
            #1;
            if (fire) idx++;
            budget++;
        end
        ld_valid = 0;
        ld_start = 0;
        checks++;
        if (idx < stream.size()) begin
            errors++;
            $display("FAIL stream_timeout sent %0d of %0d", idx, stream.size());
        end
        repeat (3) cyc();
    endtask

    task automatic add_ck(input bit bad);
        if (CK != 0) stream.push_back(img_sum() + 8'(bad));
    endtask

    initial begin
        int w0, d0, len;
        repeat (3) cyc();
        rst = 0;
        cyc();

        // basic load
        w0 = wcnt; d0 = dcnt;
        stream = '{8'h02, 8'h11, 8'h22, 8'h33};
        add_ck(0);
        send(100, 0, 0);
        chk("basic_nwr", wcnt - w0, 3);
        chk("basic_a0", wa[w0], 8'h00);
        chk("basic_a2", wa[w0 + 2], 8'h02);
        chk("basic_d0", wd[w0], 8'h11);
        chk("basic_d1", wd[w0 + 1], 8'h22);
        chk("basic_d2", wd[w0 + 2], 8'h33);
        chk("wrap_a0", ww[w0], 8'hFE);
        chk("wrap_a2", ww[w0 + 2], 8'h00);
        chk("basic_done", dcnt - d0, 1);
        chk("basic_hold", cpu_hold, 0);

        // backpressure gaps, wrap addresses on the second instance
        w0 = wcnt;
        stream = '{8'h03, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        add_ck(0);
        send(0, 1, 0);
        chk("gap_nwr", wcnt - w0, 4);
        chk("gap_a3", wa[w0 + 3], 8'h03);
        chk("wrap_a1", ww[w0 + 1], 8'hFF);
        chk("wrap_a3", ww[w0 + 3], 8'h01);

        // max length
        w0 = wcnt;
        stream = '{8'hFF};
        for (int i = 0; i < 256; i++) stream.push_back(8'($urandom));
        add_ck(0);
        send(100, 0, 0);
        chk("max_nwr", wcnt - w0, 256);
        chk("max_alast", wa[w0 + 255], 8'hFF);

        // reset after the second data byte
        w0 = wcnt;
        ld_start = 1; cyc(); ld_start = 0;
        ld_valid = 1;
        ld_data = 8'h05; cyc();
        ld_data = 8'h5A; cyc();
        ld_data = 8'hA5; cyc();
        ld_valid = 0; cyc();
        rst = 1;
        #1;
        chk("rst_we", ram_write_en, 0);
        chk("rst_addr", ram_addr, 8'h00);
        chk("rst_hold", cpu_hold, 1);
        chk("rst_ready", ld_ready, 0);
        cyc(); cyc();
        rst = 0;
        ld_valid = 1;
        for (int i = 0; i < 5; i++) begin
            ld_data = 8'($urandom);
            cyc();
        end
        ld_valid = 0;
        cyc();
        chk("rst_nwr", wcnt - w0, 2);
        chk("rst_d1", wd[w0 + 1], 8'hA5);
        chk("rst_hold2", cpu_hold, 1);

`ifdef LOADER_CHECKSUM_EN
        stream = '{8'h01, 8'h10, 8'h20, 8'h30};
        send(100, 0, 0);
        chk("ck_good_err", ld_error, 0);
        chk("ck_good_hold", cpu_hold, 0);
        d0 = dcnt;
        stream = '{8'h01, 8'h10, 8'h20, 8'h31};
        send(100, 0, 0);
        chk("ck_bad_err", ld_error, 1);
        chk("ck_bad_hold", cpu_hold, 1);
        chk("ck_bad_done", dcnt - d0, 1);
`endif

        // randomized loads with stray ld_start pulses
        for (int t = 0; t < 20; t++) begin
            len = ($urandom_range(3) == 0) ? $urandom_range(255)
                                           : $urandom_range(15);
            stream = '{8'(len)};
            for (int i = 0; i <= len; i++) stream.push_back(8'($urandom));
            add_ck($urandom_range(3) == 0);
            send($urandom_range(100, 30), 0, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
